// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer
//   Control sequencer for a two-function (add/subtract) calculator. Takes
//   debounced one-cycle key strobes and assembles multi-digit BCD-style
//   operands A and B. It selects add or subtract, issues a one-cycle execute
//   strobe to the datapath, and then holds the result for display.
//   Supports operand chaining from a previous result, a per-operand digit
//   limit, clear-entry and a soft clear-all.
//
// Parameters
//   NUM_DIGITS  4-bit digits per operand (OPW = 4*NUM_DIGITS)
//   CHAIN_EN    1: operator key in DONE reuses result as operand A
//
// Ports
//   clock       system clock, rising edge
//   clrAll      asynchronous active-low reset
//   keyValid    one-cycle key strobe
//   keyCode     0-9 digit, A add, B sub, C clear entry, D clear all,
//               E ignored, F equals
//   result      datapath result, valid the cycle after execStrobe
//   operandA    operand A register
//   operandB    operand B register
//   addSub      0 = add, 1 = subtract
//   execStrobe  one-cycle compute request (high while in EXEC)
//   showResult  high in DONE
//   digitCount  digits entered into the current operand
//   state       current state encoding
module calc_key_sequencer #(
  parameter int NUM_DIGITS = 2,
  parameter bit CHAIN_EN   = 1'b1,
  localparam int OPW = 4 * NUM_DIGITS,
  localparam int DCW = $clog2(NUM_DIGITS + 1)
) (
  input  logic           clock,
  input  logic           clrAll,
  input  logic           keyValid,
  input  logic [3:0]     keyCode,
  input  logic [OPW-1:0] result,
  output logic [OPW-1:0] operandA,
  output logic [OPW-1:0] operandB,
  output logic           addSub,
  output logic           execStrobe,
  output logic           showResult,
  output logic [DCW-1:0] digitCount,
  output logic [2:0]     state
);

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    EXEC    = 3'd2,
    DONE    = 3'd3
  } state_t;

  state_t cur_state, nxt_state;

  logic [OPW-1:0] a_nxt, b_nxt;
  logic           add_sub_nxt;
  logic [DCW-1:0] dc_nxt;

  // Key decode; every decoded key is already qualified by keyValid.
  logic key_digit, key_op, key_eq, key_ce, key_ca, clear_all, room;

  always_comb begin
    key_digit = keyValid && (keyCode <= 4'h9);
    key_op    = keyValid && ((keyCode == 4'hA) || (keyCode == 4'hB));
    key_eq    = keyValid && (keyCode == 4'hF);
    key_ce    = keyValid && (keyCode == 4'hC);
    key_ca    = keyValid && (keyCode == 4'hD);
    // Clear-entry in DONE behaves as clear-all; EXEC ignores every key.
    clear_all = (cur_state != EXEC) && (key_ca || (key_ce && (cur_state == DONE)));
    room      = (digitCount < DCW'(NUM_DIGITS));
  end

  // State register plus all registered outputs.
  always_ff @(posedge clock or negedge clrAll) begin
    if (!clrAll) begin
      cur_state  <= ENTER_A;
      operandA   <= '0;
      operandB   <= '0;
      addSub     <= 1'b0;
      digitCount <= '0;
      execStrobe <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      operandA   <= a_nxt;
      operandB   <= b_nxt;
      addSub     <= add_sub_nxt;
      digitCount <= dc_nxt;
      // Registered from the next state so the pulse spans exactly the EXEC cycle.
      execStrobe <= (nxt_state == EXEC);
    end
  end

  // Next-state logic.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ENTER_A: begin
        if (clear_all)   nxt_state = ENTER_A;
        else if (key_op) nxt_state = ENTER_B;
      end
      ENTER_B: begin
        if (clear_all)   nxt_state = ENTER_A;
        else if (key_eq) nxt_state = EXEC;
      end
      EXEC: nxt_state = DONE;
      DONE: begin
        if (clear_all || key_digit)  nxt_state = ENTER_A;
        else if (key_op && CHAIN_EN) nxt_state = ENTER_B;
        else if (key_eq)             nxt_state = EXEC;
      end
      default: nxt_state = ENTER_A;
    endcase
  end

  // Output logic: next values of the registered outputs, plus decoded showResult.
  always_comb begin
    a_nxt       = operandA;
    b_nxt       = operandB;
    add_sub_nxt = addSub;
    dc_nxt      = digitCount;
    showResult  = (cur_state == DONE);
    if (clear_all) begin
      a_nxt       = '0;
      b_nxt       = '0;
      add_sub_nxt = 1'b0;
      dc_nxt      = '0;
    end else begin
      case (cur_state)
        ENTER_A: begin
          if (key_digit && room) begin
            a_nxt  = (operandA << 4) | OPW'(keyCode);
            dc_nxt = digitCount + DCW'(1);
          end else if (key_op) begin
            add_sub_nxt = keyCode[0];
            b_nxt       = '0;
            dc_nxt      = '0;
          end else if (key_ce) begin
            a_nxt  = '0;
            dc_nxt = '0;
          end
        end
        ENTER_B: begin
          if (key_digit && room) begin
            b_nxt  = (operandB << 4) | OPW'(keyCode);
            dc_nxt = digitCount + DCW'(1);
          end else if (key_op) begin
            add_sub_nxt = keyCode[0];
          end else if (key_ce) begin
            b_nxt  = '0;
            dc_nxt = '0;
          end
        end
        DONE: begin
          if (key_digit) begin
            a_nxt  = OPW'(keyCode);
            b_nxt  = '0;
            dc_nxt = DCW'(1);
          end else if (key_op && CHAIN_EN) begin
            a_nxt       = result;
            add_sub_nxt = keyCode[0];
            b_nxt       = '0;
            dc_nxt      = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_calc_key_sequencer.sv
module tb_calc_key_sequencer;

  logic       clock = 1'b0;
  logic       clrAll;
  logic       keyValid;
  logic [3:0] keyCode;

  logic [7:0] result0 = '0, result1 = '0;
  logic [7:0] a0, b0, a1, b1;
  logic       as0, as1, ex0, ex1, sr0, sr1;
  logic [1:0] dc0, dc1;
  logic [2:0] st0, st1;

  always #5 clock = ~clock;

  calc_key_sequencer #(.NUM_DIGITS(2), .CHAIN_EN(1'b1)) u_chain (
    .clock(clock), .clrAll(clrAll), .keyValid(keyValid), .keyCode(keyCode),
    .result(result0), .operandA(a0), .operandB(b0), .addSub(as0),
    .execStrobe(ex0), .showResult(sr0), .digitCount(dc0), .state(st0)
  );

  calc_key_sequencer #(.NUM_DIGITS(2), .CHAIN_EN(1'b0)) u_nochain (
    .clock(clock), .clrAll(clrAll), .keyValid(keyValid), .keyCode(keyCode),
    .result(result1), .operandA(a1), .operandB(b1), .addSub(as1),
    .execStrobe(ex1), .showResult(sr1), .digitCount(dc1), .state(st1)
  );

  // Simple add/sub datapath: loads on the execute strobe.
  always @(posedge clock) begin
    if (ex0) result0 <= as0 ? a0 - b0 : a0 + b0;
    if (ex1) result1 <= as1 ? a1 - b1 : a1 + b1;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   fails   = 0;
  int   strobes = 0;

  // Scoreboard: every execute strobe must match the next expected operation.
  always @(negedge clock) begin
    if (ex0 === 1'b1) begin
      exp_t e;
      strobes++;
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL exec_unexpected: got strobe with a=%h b=%h sub=%b, required no strobe", a0, b0, as0);
      end else begin
        e = sb.pop_front();
        if ({a0, b0, as0} !== {e.a, e.b, e.sub}) begin
          fails++;
          $display("FAIL exec_operands: got a=%h b=%h sub=%b, required a=%h b=%h sub=%b",
                   a0, b0, as0, e.a, e.b, e.sub);
        end
      end
    end
  end

  task automatic press(input logic [3:0] k);
    @(negedge clock);
    keyValid = 1'b1;
    keyCode  = k;
    @(posedge clock);
    #1;
    keyValid = 1'b0;
    keyCode  = 4'($urandom_range(0, 15));
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic sub);
    exp_t e;
    e.a = a; e.b = b; e.sub = sub;
    sb.push_back(e);
  endtask

  // Vector order: {state, A, B, addSub, digitCount, execStrobe, showResult}
  task automatic test_reset();
    clrAll   = 1'b0;
    keyValid = 1'b1;
    keyCode  = 4'hF;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({st0, a0, b0, as0, dc0, ex0, sr0} !== {3'd0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_chain: got %h, required %h", {st0, a0, b0, as0, dc0, ex0, sr0},
               {3'd0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0});
    end
    checks++;
    if ({st1, a1, b1, as1, dc1, ex1, sr1} !== {3'd0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_nochain: got %h, required %h", {st1, a1, b1, as1, dc1, ex1, sr1},
               {3'd0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0});
    end
    @(negedge clock);
    keyValid = 1'b0;
    clrAll   = 1'b1;
    idle(1);
    checks++;
    if ({st0, a0, dc0} !== {3'd0, 8'h00, 2'd0}) begin
      fails++;
      $display("FAIL reset_release: got st=%0d a=%h dc=%0d, required st=0 a=00 dc=0", st0, a0, dc0);
    end
  endtask

  task automatic test_basic();
    int unsigned s0;
    s0 = strobes;
    press(4'h3); press(4'h7);
    checks++;
    if ({a0, dc0} !== {8'h37, 2'd2}) begin
      fails++;
      $display("FAIL basic_opA: got a=%h dc=%0d, required a=37 dc=2", a0, dc0);
    end
    press(4'hA);
    checks++;
    if ({st0, b0, as0, dc0} !== {3'd1, 8'h00, 1'b0, 2'd0}) begin
      fails++;
      $display("FAIL basic_op: got st=%0d b=%h as=%b dc=%0d, required st=1 b=00 as=0 dc=0", st0, b0, as0, dc0);
    end
    press(4'h1); press(4'h2);
    push_exp(8'h37, 8'h12, 1'b0);
    press(4'hF);
    checks++;
    if ({st0, ex0, sr0} !== {3'd2, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL basic_exec: got st=%0d ex=%b sr=%b, required st=2 ex=1 sr=0", st0, ex0, sr0);
    end
    idle(1);
    checks++;
    if ({st0, a0, b0, as0, ex0, sr0} !== {3'd3, 8'h37, 8'h12, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL basic_done: got %h, required %h", {st0, a0, b0, as0, ex0, sr0},
               {3'd3, 8'h37, 8'h12, 1'b0, 1'b0, 1'b1});
    end
    checks++;
    if (strobes !== s0 + 1) begin
      fails++;
      $display("FAIL basic_strobe_cycles: got %0d, required %0d", strobes - s0, 1);
    end
  endtask

  task automatic test_chain();
    // Both units sit in DONE with result 0x49.
    press(4'hB);
    checks++;
    if ({st0, a0, b0, as0, dc0} !== {3'd1, 8'h49, 8'h00, 1'b1, 2'd0}) begin
      fails++;
      $display("FAIL chain_on: got st=%0d a=%h b=%h as=%b dc=%0d, required st=1 a=49 b=00 as=1 dc=0",
               st0, a0, b0, as0, dc0);
    end
    checks++;
    if ({st1, a1, b1, as1, sr1} !== {3'd3, 8'h37, 8'h12, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL chain_off: got st=%0d a=%h b=%h as=%b sr=%b, required st=3 a=37 b=12 as=0 sr=1",
               st1, a1, b1, as1, sr1);
    end
    press(4'hA);
    checks++;
    if ({st0, as0} !== {3'd1, 1'b0}) begin
      fails++;
      $display("FAIL enterb_add: got st=%0d as=%b, required st=1 as=0", st0, as0);
    end
    press(4'hB);
    checks++;
    if ({st0, as0} !== {3'd1, 1'b1}) begin
      fails++;
      $display("FAIL enterb_sub: got st=%0d as=%b, required st=1 as=1", st0, as0);
    end
    press(4'hD);
    checks++;
    if ({st0, a0, b0, as0, dc0, ex0, sr0} !== {3'd0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL clear_all_enterb: got %h, required 0", {st0, a0, b0, as0, dc0, ex0, sr0});
    end
    checks++;
    if ({st1, a1, b1, as1, dc1, ex1, sr1} !== {3'd0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL clear_all_done: got %h, required 0", {st1, a1, b1, as1, dc1, ex1, sr1});
    end
  endtask

  task automatic test_digit_limit();
    press(4'h1); press(4'h2); press(4'h3);
    checks++;
    if ({st0, a0, dc0} !== {3'd0, 8'h12, 2'd2}) begin
      fails++;
      $display("FAIL digit_limit: got st=%0d a=%h dc=%0d, required st=0 a=12 dc=2", st0, a0, dc0);
    end
    press(4'hE); press(4'hF);
    checks++;
    if ({st0, a0, dc0, ex0} !== {3'd0, 8'h12, 2'd2, 1'b0}) begin
      fails++;
      $display("FAIL ignored_keys: got st=%0d a=%h dc=%0d ex=%b, required st=0 a=12 dc=2 ex=0",
               st0, a0, dc0, ex0);
    end
    press(4'hC);
    checks++;
    if ({st0, a0, dc0} !== {3'd0, 8'h00, 2'd0}) begin
      fails++;
      $display("FAIL clear_entry: got st=%0d a=%h dc=%0d, required st=0 a=00 dc=0", st0, a0, dc0);
    end
    press(4'h9);
    checks++;
    if ({a0, dc0} !== {8'h09, 2'd1}) begin
      fails++;
      $display("FAIL digit_after_ce: got a=%h dc=%0d, required a=09 dc=1", a0, dc0);
    end
    press(4'hD);
  endtask

  task automatic test_repeat_exec();
    int unsigned s0;
    press(4'h5); press(4'h4); press(4'hB); press(4'h2); press(4'h1);
    s0 = strobes;
    push_exp(8'h54, 8'h21, 1'b1);
    press(4'hF);
    idle(1);
    push_exp(8'h54, 8'h21, 1'b1);
    press(4'hF);
    checks++;
    if (ex0 !== 1'b1) begin
      fails++;
      $display("FAIL repeat_exec_pulse: got ex=%b, required 1", ex0);
    end
    idle(1);
    push_exp(8'h54, 8'h21, 1'b1);
    press(4'hF);
    idle(1);
    checks++;
    if (strobes !== s0 + 3) begin
      fails++;
      $display("FAIL repeat_exec_count: got %0d, required %0d", strobes - s0, 3);
    end
    checks++;
    if ({st0, a0, b0, as0, sr0} !== {3'd3, 8'h54, 8'h21, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL repeat_exec_hold: got st=%0d a=%h b=%h as=%b sr=%b, required st=3 a=54 b=21 as=1 sr=1",
               st0, a0, b0, as0, sr0);
    end
    press(4'h7);
    checks++;
    if ({st0, a0, b0, dc0, sr0} !== {3'd0, 8'h07, 8'h00, 2'd1, 1'b0}) begin
      fails++;
      $display("FAIL done_digit: got st=%0d a=%h b=%h dc=%0d sr=%b, required st=0 a=07 b=00 dc=1 sr=0",
               st0, a0, b0, dc0, sr0);
    end
    press(4'hD);
  endtask

  task automatic test_abort();
    press(4'h1); press(4'hA); press(4'h2);
    push_exp(8'h01, 8'h02, 1'b0);
    press(4'hF);
    checks++;
    if (ex0 !== 1'b1) begin
      fails++;
      $display("FAIL abort_pre: got ex=%b, required 1", ex0);
    end
    #1;
    clrAll   = 1'b0;
    keyValid = 1'b1;
    keyCode  = 4'hF;
    #1;
    checks++;
    if ({st0, a0, b0, as0, dc0, ex0, sr0} !== {3'd0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL abort_async: got %h, required 0", {st0, a0, b0, as0, dc0, ex0, sr0});
    end
    // The aborted operation never reaches the datapath.
    sb.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    keyValid = 1'b0;
    clrAll   = 1'b1;
    idle(2);
    checks++;
    if ({st0, a0, b0, ex0, sr0} !== {3'd0, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL abort_release: got st=%0d a=%h b=%h ex=%b sr=%b, required all 0", st0, a0, b0, ex0, sr0);
    end
  endtask

  initial begin
    keyValid = 1'b0;
    keyCode  = 4'h0;
    clrAll   = 1'b0;
    test_reset();
    test_basic();
    test_chain();
    test_digit_limit();
    test_repeat_exec();
    test_abort();
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
